// File: rtl/energy_term_streamer.sv
// rtl/energy_term_streamer.sv - latches signed energy terms and streams them into the accumulator
// Outputs are combinational decodes of state, index, shadow terms, hold_i and abort_i.
module energy_term_streamer #(
    parameter int NUM_TERMS = 16,
    parameter int OUT_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [NUM_TERMS*OUT_WIDTH-1:0] terms_i,
    input  logic                           hold_i,
    input  logic                           abort_i,
    output logic                           busy_o,
    output logic                           clear_o,
    output logic                           en_o,
    output logic                           valid_o,
    output logic signed [OUT_WIDTH-1:0]    data_o,
    output logic                           last_o,
    output logic                           done_o
);

    localparam int IDX_WIDTH = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_TERMS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [OUT_WIDTH-1:0]   shadow_q [NUM_TERMS];
    logic [OUT_WIDTH-1:0]   shadow_d [NUM_TERMS];

    logic stream_beat;
    logic final_beat;

    // A beat is only offered when neither back-pressure nor abort is present.
    assign stream_beat = (state_q == S_STREAM) && !hold_i && !abort_i;
    assign final_beat  = stream_beat && (idx_q == LAST_IDX);

    assign busy_o  = (state_q != S_IDLE);
    assign clear_o = (state_q == S_CLEAR);
    assign en_o    = (state_q == S_STREAM);
    assign valid_o = stream_beat;
    assign last_o  = final_beat;
    assign done_o  = (state_q == S_DONE) && !abort_i;
    assign data_o  = stream_beat ? shadow_q[idx_q] : '0;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    for (int k = 0; k < NUM_TERMS; k++) begin
                        shadow_d[k] = terms_i[k*OUT_WIDTH +: OUT_WIDTH];
                    end
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                idx_d   = '0;
                state_d = abort_i ? S_IDLE : S_STREAM;
            end
            S_STREAM: begin
                if (abort_i) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else if (final_beat) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else if (stream_beat) begin
                    idx_d = idx_q + IDX_WIDTH'(1);
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            for (int k = 0; k < NUM_TERMS; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: tb/tb_energy_term_streamer.sv
// tb/tb_energy_term_streamer.sv - directed bench for energy_term_streamer with accumulator model
module tb_energy_term_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, hold = 1'b0, abort = 1'b0;
    logic [63:0] terms;
    logic        busy_o, clear_o, en_o, valid_o, last_o, done_o;
    logic signed [15:0] data_o;

    logic        start1 = 1'b0;
    logic [15:0] terms1;
    logic        busy1, clear1, en1, valid1, last1, done1;
    logic signed [15:0] data1;

    int n_checks = 0;
    int n_errors = 0;
    int acc = 0;
    int acc1 = 0;

    always #5 clk = ~clk;

    energy_term_streamer #(.NUM_TERMS(4), .OUT_WIDTH(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .terms_i(terms),
        .hold_i(hold), .abort_i(abort), .busy_o(busy_o), .clear_o(clear_o),
        .en_o(en_o), .valid_o(valid_o), .data_o(data_o), .last_o(last_o), .done_o(done_o)
    );

    energy_term_streamer #(.NUM_TERMS(1), .OUT_WIDTH(16)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .terms_i(terms1),
        .hold_i(1'b0), .abort_i(1'b0), .busy_o(busy1), .clear_o(clear1),
        .en_o(en1), .valid_o(valid1), .data_o(data1), .last_o(last1), .done_o(done1)
    );

    // Downstream accumulator models: registered running sum with synchronous clear.
    always @(posedge clk) begin
        if (clear_o) acc <= 0;
        else if (en_o && valid_o) acc <= acc + int'(data_o);
        if (clear1) acc1 <= 0;
        else if (en1 && valid1) acc1 <= acc1 + int'(data1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic s, input logic h, input logic a,
                       input int ec, input int ee, input int ev, input int el,
                       input int ed, input int eb, input int edata);
        start = s; hold = h; abort = a;
        @(negedge clk);
        chk({tag, ".clear"}, int'(clear_o), ec);
        chk({tag, ".en"},    int'(en_o),    ee);
        chk({tag, ".valid"}, int'(valid_o), ev);
        chk({tag, ".last"},  int'(last_o),  el);
        chk({tag, ".done"},  int'(done_o),  ed);
        chk({tag, ".busy"},  int'(busy_o),  eb);
        chk({tag, ".data"},  int'(data_o),  edata);
        @(posedge clk); #1;
        start = 1'b0; hold = 1'b0; abort = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".busy"},  int'(busy_o),  0);
        chk({tag, ".clear"}, int'(clear_o), 0);
        chk({tag, ".en"},    int'(en_o),    0);
        chk({tag, ".valid"}, int'(valid_o), 0);
        chk({tag, ".last"},  int'(last_o),  0);
        chk({tag, ".done"},  int'(done_o),  0);
        chk({tag, ".data"},  int'(data_o),  0);
    endtask

    task automatic run_t2(input string tag);
        cyc({tag, "c0"}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc({tag, "c1"}, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc({tag, "c2"}, 0, 0, 0, 0, 1, 1, 0, 0, 1, 3);
        cyc({tag, "c3"}, 0, 0, 0, 0, 1, 1, 0, 0, 1, -5);
        cyc({tag, "c4"}, 0, 0, 0, 0, 1, 1, 0, 0, 1, 7);
        cyc({tag, "c5"}, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        cyc({tag, "c6"}, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk({tag, ".sum"}, acc, 6);
        cyc({tag, "c7"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        terms  = {16'h0001, 16'h0007, 16'hFFFB, 16'h0003};
        terms1 = 16'hFFF9;
        #3;
        all_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T2: plain run
        run_t2("t2");

        // T3: hold in cycles 3-4
        cyc("t3c0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3c1", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc("t3c2", 0, 0, 0, 0, 1, 1, 0, 0, 1, 3);
        cyc("t3c3", 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        cyc("t3c4", 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        cyc("t3c5", 0, 0, 0, 0, 1, 1, 0, 0, 1, -5);
        cyc("t3c6", 0, 0, 0, 0, 1, 1, 0, 0, 1, 7);
        cyc("t3c7", 0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        cyc("t3c8", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t3.sum", acc, 6);
        cyc("t3c9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // T4: start with new terms while busy is ignored
        cyc("t4c0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4c1", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc("t4c2", 0, 0, 0, 0, 1, 1, 0, 0, 1, 3);
        terms = {16'h0009, 16'h0009, 16'h0009, 16'h0009};
        cyc("t4c3", 1, 0, 0, 0, 1, 1, 0, 0, 1, -5);
        cyc("t4c4", 0, 0, 0, 0, 1, 1, 0, 0, 1, 7);
        cyc("t4c5", 0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        cyc("t4c6", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t4.sum", acc, 6);
        cyc("t4c7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        terms = {16'h0001, 16'h0007, 16'hFFFB, 16'h0003};

        // T5: abort in cycle 4, then a fresh run from term 0
        cyc("t5c0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5c1", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc("t5c2", 0, 0, 0, 0, 1, 1, 0, 0, 1, 3);
        cyc("t5c3", 0, 0, 0, 0, 1, 1, 0, 0, 1, -5);
        cyc("t5c4", 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        cyc("t5c5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5.partial", acc, -2);
        run_t2("t5r");

        // T6: extremes; start+abort in IDLE (start wins), hold during CLEAR ignored
        terms = {16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000};
        cyc("t6c0", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t6c1", 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc("t6c2", 0, 0, 0, 0, 1, 1, 0, 0, 1, -32768);
        cyc("t6c3", 0, 0, 0, 0, 1, 1, 0, 0, 1, 32767);
        cyc("t6c4", 0, 0, 0, 0, 1, 1, 0, 0, 1, -1);
        cyc("t6c5", 0, 0, 0, 0, 1, 1, 1, 0, 1, -32768);
        cyc("t6c6", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t6.sum", acc, -32770);
        cyc("t6c7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        terms = {16'h0001, 16'h0007, 16'hFFFB, 16'h0003};

        // T1: asynchronous reset mid-stream
        cyc("t1c0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t1c1", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc("t1c2", 0, 0, 0, 0, 1, 1, 0, 0, 1, 3);
        #2 rst_n = 1'b0;
        #1 all_zero("t1rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("t1post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // T7: single-term instance
        start1 = 1'b1;
        @(negedge clk);
        chk("t7c0.busy", int'(busy1), 0);
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        chk("t7c1.clear", int'(clear1), 1);
        chk("t7c1.valid", int'(valid1), 0);
        @(negedge clk);
        chk("t7c2.valid", int'(valid1), 1);
        chk("t7c2.last",  int'(last1),  1);
        chk("t7c2.data",  int'(data1),  -7);
        chk("t7c2.done",  int'(done1),  0);
        @(negedge clk);
        chk("t7c3.done",  int'(done1),  1);
        chk("t7c3.valid", int'(valid1), 0);
        chk("t7.sum",     acc1,         -7);
        @(negedge clk);
        chk("t7c4.busy",  int'(busy1),  0);
        chk("t7c4.done",  int'(done1),  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
